// File: rtl/disp_sched.sv
// disp_sched -- round-robin scheduler that shares one 2-digit BCD display
// between four sources.
//
// A source asks for the display by raising its req bit. The granted source
// keeps the display for DWELL cycles while others wait, then the grant
// rotates round-robin. If nobody else is waiting, the grant is held
// indefinitely. While a source is shown, its live data is copied to num
// every cycle. Any non-decimal nibble is blanked to 0, and the sticky err
// flag is raised.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   req[3:0]   per-source display request
//   data[31:0] per-source BCD pair, source i on data[8i+7:8i] (tens in upper nibble)
//   gnt[3:0]   registered one-hot grant, zero when idle
//   num[7:0]   registered sanitised BCD pair of the granted source
//   num_valid  registered, high while gnt is non-zero
//   err        sticky: a granted source presented a nibble above 9
module disp_sched #(
  parameter int DWELL = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  gnt,
  output logic [7:0]  num,
  output logic        num_valid,
  output logic        err
);

  localparam logic [15:0] CNT_MAX = 16'(DWELL - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  gnt_reg, gnt_next;
  logic [7:0]  num_reg, num_next;
  logic        valid_reg, valid_next;
  logic        err_reg, err_next;
  logic [15:0] cnt_reg, cnt_next;
  // Index of the current or most recent grant. In SHOW it is the shown source.
  logic [1:0]  last_reg, last_next;

  // Per-source sanitised value and bad-nibble flag.
  logic [7:0] src_clean [4];
  logic [3:0] src_bad;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_src
      logic [3:0] hi;
      logic [3:0] lo;
      assign hi = data[8*gi+7 -: 4];
      assign lo = data[8*gi+3 -: 4];
      assign src_clean[gi] = {(hi > 4'd9) ? 4'd0 : hi, (lo > 4'd9) ? 4'd0 : lo};
      assign src_bad[gi]   = (hi > 4'd9) || (lo > 4'd9);
    end
  endgenerate

  // Search for the first set bit of r, starting at last+1 and wrapping around.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  logic       grant_new;
  logic [1:0] sel;

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    num_next   = num_reg;
    valid_next = valid_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    grant_new  = 1'b0;
    sel        = last_reg;

    case (state_reg)
      IDLE: begin
        if (req != 4'b0000) begin
          grant_new = 1'b1;
          sel       = rr_pick(req, last_reg);
        end
      end
      SHOW: begin
        if (!req[last_reg]) begin
          // A drop wins over dwell expiry. Hand over at once, or go idle.
          if (req == 4'b0000) begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
            valid_next = 1'b0;
            cnt_next   = 16'd0;
          end else begin
            grant_new = 1'b1;
            sel       = rr_pick(req, last_reg);
          end
        end else if (cnt_reg == CNT_MAX && (req & ~gnt_reg) != 4'b0000) begin
          // The current source is masked out so the search cannot land on it.
          grant_new = 1'b1;
          sel       = rr_pick(req & ~gnt_reg, last_reg);
        end else begin
          num_next = src_clean[last_reg];
          err_next = err_reg | src_bad[last_reg];
          if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 16'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (grant_new) begin
      state_next = SHOW;
      gnt_next   = 4'b0001 << sel;
      last_next  = sel;
      cnt_next   = 16'd0;
      valid_next = 1'b1;
      num_next   = src_clean[sel];
      err_next   = err_reg | src_bad[sel];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      gnt_reg   <= 4'b0000;
      num_reg   <= 8'h00;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= 16'd0;
      last_reg  <= 2'd3;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      num_reg   <= num_next;
      valid_reg <= valid_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  assign gnt       = gnt_reg;
  assign num       = num_reg;
  assign num_valid = valid_reg;
  assign err       = err_reg;

endmodule
